// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide/remainder unit:
// operation encodings, controller state encoding and the default width.
package div_pkg;

  // Default operand/result width of the divider.
  localparam int DIV_XLEN = 32;

  // Operation encoding as presented on the op port.
  // Bit 1 selects remainder vs quotient, bit 0 selects unsigned vs signed.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

  // Signed operations are the ones with op[0] clear (DIV, REM).
  function automatic logic div_op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left by one, try to
// subtract the divisor from the shifted partial remainder and shift the
// resulting quotient bit into q. Purely combinational.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] r_next,
  output logic [XLEN-1:0] q_next
);

  // The shifted remainder needs one extra bit: with a divisor above
  // 2^(XLEN-1) the partial remainder can exceed XLEN bits after the shift.
  logic [XLEN:0]   r_shift;
  logic [XLEN-1:0] diff;
  logic            take;

  assign r_shift = {r, q[XLEN-1]};
  assign take    = (r_shift >= {1'b0, divisor});
  // When take is set the true difference is below the divisor, so the
  // XLEN-bit modular subtraction is exact.
  assign diff    = r_shift[XLEN-1:0] - divisor;
  assign r_next  = take ? diff : r_shift[XLEN-1:0];
  assign q_next  = {q[XLEN-2:0], take};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) with a
// valid/ready handshake. One restoring quotient bit is produced per cycle
// on magnitudes; signs are applied in a single fix-up cycle afterwards.
//
// Optional build macro DIV_FAST_PATH_EN: when defined, divide-by-zero,
// signed overflow and |A| < |B| are resolved at accept time and the unit
// jumps straight to DONE. Results are identical in both builds.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] O,
  output logic            busy
);

  div_state_e state_reg, state_next;

  logic            sel_rem_reg;   // 1: result is the remainder
  logic            sa_reg;        // dividend was negative (signed ops only)
  logic            sb_reg;        // divisor was negative (signed ops only)
  logic [XLEN-1:0] r_reg;         // partial remainder
  logic [XLEN-1:0] q_reg;         // dividend shifting out / quotient shifting in
  logic [XLEN-1:0] d_reg;         // divisor magnitude
  logic [CNT_W-1:0] cnt_reg;      // remaining iterations minus one
  logic [XLEN-1:0] o_reg;         // registered result

  // Accept-side operand decode.
  logic            is_signed;
  logic            sa_in;
  logic            sb_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            accept;
  logic            fast_hit;

  // Iteration and fix-up results.
  logic [XLEN-1:0] r_step;
  logic [XLEN-1:0] q_step;
  logic            neg_q;
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  assign is_signed = div_op_is_signed(op);
  assign sa_in     = is_signed & A[XLEN-1];
  assign sb_in     = is_signed & B[XLEN-1];
  // Negating the most negative value wraps to itself, which is exactly the
  // unsigned magnitude 2^(XLEN-1) the iteration needs.
  assign a_mag     = sa_in ? -A : A;
  assign b_mag     = sb_in ? -B : B;
  assign accept    = (state_reg == DIV_IDLE) && in_valid && !flush;

`ifdef DIV_FAST_PATH_EN
  logic            fast_b_zero;
  logic            fast_ovf;
  logic            fast_small;
  logic [XLEN-1:0] fast_quo;
  logic [XLEN-1:0] fast_rem;
  logic [XLEN-1:0] fast_result;

  assign fast_b_zero = (B == '0);
  assign fast_ovf    = is_signed && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  assign fast_small  = (a_mag < b_mag);
  assign fast_hit    = fast_b_zero | fast_ovf | fast_small;
  // Divide-by-zero: quotient all ones, remainder the dividend.
  // Overflow: quotient the dividend (most negative value), remainder zero.
  // |A| < |B|: quotient zero, remainder the dividend with its own sign.
  assign fast_quo    = fast_b_zero ? '1 : (fast_ovf ? A : '0);
  assign fast_rem    = fast_ovf ? '0 : A;
  assign fast_result = op[1] ? fast_rem : fast_quo;
`else
  assign fast_hit    = 1'b0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .r       (r_reg),
    .q       (q_reg),
    .divisor (d_reg),
    .r_next  (r_step),
    .q_next  (q_step)
  );

  // A zero divisor must give an all-ones quotient regardless of the
  // dividend's sign, so the quotient sign correction is suppressed then.
  assign neg_q     = (sa_reg ^ sb_reg) && (d_reg != '0);
  assign quo_fixed = neg_q  ? -q_reg : q_reg;
  assign rem_fixed = sa_reg ? -r_reg : r_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DIV_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      DIV_IDLE: begin
        if (in_valid && !flush) begin
          state_next = fast_hit ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (flush) begin
          state_next = DIV_IDLE;
        end else if (cnt_reg == '0) begin
          state_next = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_next = flush ? DIV_IDLE : DIV_DONE;
      end
      DIV_DONE: begin
        if (flush || out_ready) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_reg)
      DIV_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DIV_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign O = o_reg;

  // Datapath: latch operands on accept, iterate in CALC, sign-fix in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_rem_reg <= 1'b0;
      sa_reg      <= 1'b0;
      sb_reg      <= 1'b0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt_reg     <= '0;
      o_reg       <= '0;
    end else begin
      unique case (state_reg)
        DIV_IDLE: begin
          if (accept) begin
            sel_rem_reg <= op[1];
            sa_reg      <= sa_in;
            sb_reg      <= sb_in;
            r_reg       <= '0;
            q_reg       <= a_mag;
            d_reg       <= b_mag;
            cnt_reg     <= CNT_W'(XLEN - 1);
`ifdef DIV_FAST_PATH_EN
            if (fast_hit) begin
              o_reg <= fast_result;
            end
`endif
          end
        end
        DIV_CALC: begin
          if (!flush) begin
            r_reg   <= r_step;
            q_reg   <= q_step;
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DIV_FIX: begin
          if (!flush) begin
            o_reg <= sel_rem_reg ? rem_fixed : quo_fixed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
